// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
//   spi_state_t : controller FSM states
//   SPI_*_DEF   : default parameter values used by the controller
//   spi_word_t  : data word at the default frame width
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_t;

  localparam int SPI_NUM_SLAVES_DEF = 4;
  localparam int SPI_DATA_W_DEF     = 8;
  localparam int SPI_CLK_DIV_DEF    = 4;
  localparam int SPI_CS_SETUP_DEF   = 2;

  typedef logic [SPI_DATA_W_DEF-1:0] spi_word_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for the SPI master.
// While en is high, sclk spends CLK_DIV cycles low, then CLK_DIV cycles high,
// starting low. rise_stb / fall_stb are high in the cycle before sclk goes
// high / low, so logic registering on the same edge lines up with the SCLK edge.
// Dropping en clears the counter and forces sclk low, so each enable burst
// starts from the same phase.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : run the divider
//   sclk      : registered SPI clock
//   rise_stb  : sclk rises on the next clk edge
//   fall_stb  : sclk falls on the next clk edge
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic          sclk_reg;
  logic          wrap;

  assign wrap     = en && (div_cnt_reg == CW'(CLK_DIV - 1));
  assign rise_stb = wrap && !sclk_reg;
  assign fall_stb = wrap && sclk_reg;
  assign sclk     = sclk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one full-duplex DATA_W-bit frame per accepted request,
// MSB first, to one of NUM_SLAVES chip selects. The received word is returned
// with a one-cycle rsp_valid pulse.
// Build option: define SPI_MASTER_LOOPBACK_EN to shift mosi back into the RX
// register instead of miso (miso is then ignored; timing is unchanged).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_slave_id, req_data   : target slave and word to send, sampled at acceptance
//   rsp_valid                : one-cycle completion pulse
//   rsp_data, rsp_err        : received word / out-of-range slave id
//   busy                     : controller not in IDLE
//   sclk, cs_n, mosi, miso   : SPI bus
// ID_W defaults to the minimal id width; it may be widened so that ids beyond
// NUM_SLAVES can be presented (they complete immediately with rsp_err).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int NUM_SLAVES = SPI_NUM_SLAVES_DEF,
  parameter int DATA_W     = SPI_DATA_W_DEF,
  parameter int CLK_DIV    = SPI_CLK_DIV_DEF,
  parameter int CS_SETUP   = SPI_CS_SETUP_DEF,
  parameter int ID_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_W-1:0]       req_slave_id,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  sclk,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int PH_W  = $clog2(CS_SETUP + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  spi_state_t             state_reg, state_next;
  logic [PH_W-1:0]        phase_cnt_reg;
  logic [BIT_W-1:0]       bit_cnt_reg;
  logic [DATA_W-1:0]      tx_reg, rx_reg, rsp_data_reg;
  logic                   err_reg;
  logic [NUM_SLAVES-1:0]  cs_n_reg;
  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic                   id_ok, accept, phase_done, last_fall, rx_bit;
  logic                   rise_stb, fall_stb, sclk_en;

  // Slave select decode of the incoming id; out-of-range ids select nothing.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cs_dec
    assign sel_onehot[gi] = (32'(req_slave_id) == gi);
  end

  assign id_ok      = 32'(req_slave_id) < 32'(NUM_SLAVES);
  assign accept     = (state_reg == IDLE) && req_valid;
  assign phase_done = (phase_cnt_reg == PH_W'(CS_SETUP - 1));
  assign last_fall  = fall_stb && (bit_cnt_reg == BIT_W'(DATA_W - 1));
  assign sclk_en    = (state_reg == SHIFT);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = tx_reg[DATA_W-1];
`else
  assign rx_bit = miso;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = id_ok ? SETUP : DONE;
      SETUP:   if (phase_done) state_next = SHIFT;
      SHIFT:   if (last_fall) state_next = HOLD;
      HOLD:    if (phase_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rsp_data_reg  <= '0;
      err_reg       <= 1'b0;
      cs_n_reg      <= '1;
    end else begin
      // SETUP and HOLD share one dwell counter, restarted on every state change.
      if (state_next != state_reg)
        phase_cnt_reg <= '0;
      else if (state_reg == SETUP || state_reg == HOLD)
        phase_cnt_reg <= phase_cnt_reg + 1'b1;

      if (state_reg != SHIFT)
        bit_cnt_reg <= '0;
      else if (fall_stb)
        bit_cnt_reg <= bit_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            err_reg <= !id_ok;
            rx_reg  <= '0;
            if (id_ok) begin
              tx_reg   <= req_data;
              cs_n_reg <= ~sel_onehot;
            end else begin
              tx_reg       <= '0;
              rsp_data_reg <= '0;
            end
          end
        end
        SHIFT: begin
          if (rise_stb)
            rx_reg <= (rx_reg << 1) | DATA_W'(rx_bit);
          // The last bit stays on mosi through HOLD.
          if (fall_stb && !last_fall)
            tx_reg <= tx_reg << 1;
        end
        HOLD: begin
          if (phase_done) begin
            cs_n_reg     <= '1;
            tx_reg       <= '0;
            rsp_data_reg <= rx_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = err_reg;
  assign cs_n      = cs_n_reg;
  assign mosi      = tx_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int NS    = 4;
  localparam int DW    = 8;
  localparam int DIV   = 4;
  localparam int CSS   = 2;
  localparam int LAT   = 2*CSS + 2*DIV*DW + 1;   // 69
  localparam int CSLOW = 2*CSS + 2*DIV*DW;       // cycles with a CS low
  localparam int LAT_F = 2*1 + 2*1*DW + 1;       // 19 for CLK_DIV=1, CS_SETUP=1

  logic            clk = 1'b0;
  logic            rst = 1'b1;

  // Main instance: default timing, 3-bit id so out-of-range ids can be sent.
  logic            req_valid = 1'b0, req_ready;
  logic [2:0]      req_slave_id = '0;
  spi_word_t       req_data = '0;
  logic            rsp_valid, rsp_err, busy, sclk, mosi, miso;
  spi_word_t       rsp_data;
  logic [NS-1:0]   cs_n;

  // Fast instance: CLK_DIV=1, CS_SETUP=1.
  logic            req_valid_f = 1'b0, req_ready_f;
  logic [1:0]      req_slave_id_f = '0;
  spi_word_t       req_data_f = '0;
  logic            rsp_valid_f, rsp_err_f, busy_f, sclk_f, mosi_f, miso_f;
  spi_word_t       rsp_data_f;
  logic [NS-1:0]   cs_n_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.NUM_SLAVES(NS), .DATA_W(DW), .CLK_DIV(DIV), .CS_SETUP(CSS), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_slave_id(req_slave_id), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master_ctrl #(.NUM_SLAVES(NS), .DATA_W(DW), .CLK_DIV(1), .CS_SETUP(1)) dut_f (
    .clk(clk), .rst(rst), .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_slave_id(req_slave_id_f), .req_data(req_data_f), .rsp_valid(rsp_valid_f),
    .rsp_data(rsp_data_f), .rsp_err(rsp_err_f), .busy(busy_f), .sclk(sclk_f),
    .cs_n(cs_n_f), .mosi(mosi_f), .miso(miso_f)
  );

  // Mode-0 slaves: present bit 7 when selected, advance one bit per SCLK fall.
  spi_word_t slave_byte = '0, slave_byte_f = '0;
  logic sel, sel_f;
  int   sl_idx = 0, sl_idx_f = 0;
  assign sel   = ~&cs_n;
  assign sel_f = ~&cs_n_f;
  always @(negedge sclk or negedge sel)
    if (!sel) sl_idx <= 0; else sl_idx <= sl_idx + 1;
  always @(negedge sclk_f or negedge sel_f)
    if (!sel_f) sl_idx_f <= 0; else sl_idx_f <= sl_idx_f + 1;
  assign miso   = (sel && sl_idx < 8) ? slave_byte[7 - sl_idx] : 1'b0;
  assign miso_f = (sel_f && sl_idx_f < 8) ? slave_byte_f[7 - sl_idx_f] : 1'b0;

  // Bus monitors: free-running counters, read as differences per frame.
  logic [NS-1:0] exp_cs = '1;
  int        rise_total = 0, cs_bad = 0, cs_low_cycles = 0, cs_multi = 0, rsp_pulses = 0;
  int        rise_f = 0, toggles_f = 0, cs_multi_f = 0;
  spi_word_t mosi_hist = '0, mosi_hist_f = '0;
  logic      sclk_f_prev = 1'b0;

  always @(posedge sclk) begin
    rise_total <= rise_total + 1;
    mosi_hist  <= {mosi_hist[6:0], mosi};
    if (cs_n !== exp_cs) cs_bad <= cs_bad + 1;
  end
  always @(posedge sclk_f) begin
    rise_f      <= rise_f + 1;
    mosi_hist_f <= {mosi_hist_f[6:0], mosi_f};
  end
  always @(negedge clk) begin
    if (cs_n != '1) cs_low_cycles <= cs_low_cycles + 1;
    if ($countones(~cs_n) > 1) cs_multi <= cs_multi + 1;
    if ($countones(~cs_n_f) > 1) cs_multi_f <= cs_multi_f + 1;
    if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    if (sclk_f != sclk_f_prev) toggles_f <= toggles_f + 1;
    sclk_f_prev <= sclk_f;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the word returned for a valid slave.
  function automatic spi_word_t model_rx(input spi_word_t d, input spi_word_t sb);
`ifdef SPI_MASTER_LOOPBACK_EN
    return d;
`else
    return sb;
`endif
  endfunction

  // One request on the main instance. With chain set, req_valid stays high
  // and the next request is presented right after this one is accepted.
  task automatic xfer(input logic [2:0] id, input spi_word_t d, input spi_word_t sb,
                      input bit chain, input logic [2:0] nid, input spi_word_t nd,
                      output int wait_cyc);
    int n, r0, c0, b0;
    bit ok;
    logic [NS-1:0] one;
    ok = (int'(id) < NS);
    one = NS'(1) << id;
    slave_byte = sb;
    exp_cs = ok ? ~one : '1;
    req_valid = 1'b1; req_slave_id = id; req_data = d;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 200) begin @(negedge clk); wait_cyc++; end
    chk("accept_ready", req_ready, 1'b1);
    r0 = rise_total; c0 = cs_low_cycles; b0 = cs_bad;
    @(negedge clk); n = 1;
    if (chain) begin
      req_slave_id = nid; req_data = nd;
    end else begin
      req_valid = 1'b0; req_slave_id = 3'($urandom); req_data = spi_word_t'($urandom);
    end
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("latency", n, ok ? LAT : 1);
    chk("rsp_err", rsp_err, !ok);
    chk("cs_pattern", cs_bad - b0, 0);
    if (ok) begin
      chk("rsp_data", rsp_data, model_rx(d, sb));
      chk("mosi_bits", mosi_hist, d);
      chk("sclk_pulses", rise_total - r0, DW);
      chk("cs_low_cycles", cs_low_cycles - c0, CSLOW);
    end else begin
      chk("sclk_pulses_err", rise_total - r0, 0);
      chk("cs_low_err", cs_low_cycles - c0, 0);
    end
    $display("xfer id=%0d data=%h slave=%h rsp=%h err=%0d lat=%0d", id, d, sb, rsp_data, rsp_err, n);
  endtask

  initial begin
    int w, n, p0, r0, t0;
    spi_word_t sb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_mosi", mosi, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames: echo slave, invalid id, loopback-style pattern
    xfer(3'd0, 8'hA5, 8'h3C, 1'b0, 3'd0, 8'h00, w);
    @(negedge clk);
    xfer(3'd5, 8'h77, 8'h12, 1'b0, 3'd0, 8'h00, w);
    @(negedge clk);
    xfer(3'd1, 8'h5A, 8'hFF, 1'b0, 3'd0, 8'h00, w);
    @(negedge clk);

    // Back-to-back with req_valid held
    xfer(3'd1, 8'hFF, 8'h96, 1'b1, 3'd3, 8'h00, w);
    xfer(3'd3, 8'h00, 8'h69, 1'b0, 3'd0, 8'h00, w);
    chk("b2b_gap", w, 1);
    chk("cs_never_two_low", cs_multi, 0);

    // Randomised frames, including out-of-range ids
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sb = spi_word_t'($urandom);
      xfer(3'($urandom_range(0, 7)), spi_word_t'($urandom), sb, 1'b0, 3'd0, 8'h00, w);
    end

    // Reset in cycle T+30 of a frame
    @(negedge clk);
    slave_byte = spi_word_t'($urandom);
    req_valid = 1'b1; req_slave_id = 3'd2; req_data = spi_word_t'($urandom);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk); req_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("busy_mid_frame", busy, 1'b1);
    p0 = rsp_pulses;
    rst = 1'b1;
    #1;
    chk("abort_cs_n", cs_n, 4'hF);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_rsp_data", rsp_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", req_ready, 1'b1);
    repeat (100) @(negedge clk);
    chk("abort_no_rsp", rsp_pulses - p0, 0);
    $display("abort id=2 at cycle 30 rsp_pulses=%0d", rsp_pulses - p0);

    // Fast instance: CLK_DIV=1, CS_SETUP=1, data 8'h81
    slave_byte_f = spi_word_t'($urandom);
    req_valid_f = 1'b1; req_slave_id_f = 2'd2; req_data_f = 8'h81;
    n = 0;
    while (!req_ready_f && n < 200) begin @(negedge clk); n++; end
    r0 = rise_f; t0 = toggles_f;
    @(negedge clk); n = 1;
    req_valid_f = 1'b0; req_data_f = spi_word_t'($urandom);
    while (!rsp_valid_f && n < 200) begin @(negedge clk); n++; end
    chk("fast_latency", n, LAT_F);
    chk("fast_rsp_data", rsp_data_f, model_rx(8'h81, slave_byte_f));
    chk("fast_rsp_err", rsp_err_f, 1'b0);
    chk("fast_mosi_bits", mosi_hist_f, 8'h81);
    chk("fast_sclk_pulses", rise_f - r0, DW);
    chk("fast_sclk_toggles", toggles_f - t0, 2*DW);
    chk("fast_cs_single", cs_multi_f, 0);
    $display("xfer_fast id=2 data=81 slave=%h rsp=%h lat=%0d", slave_byte_f, rsp_data_f, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
